// File: rtl/switch_pkg.sv
// Shared types and constants for the 4-port switch egress path.
package switch_pkg;

    localparam int PORT_CNT = 4;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;

    // One queued packet as stored in an egress FIFO entry.
    typedef struct packed {
        logic [ADDR_W-1:0] source;
        logic [ADDR_W-1:0] target;
        logic [DATA_W-1:0] data;
    } pkt_t;

    // Increment an index modulo n. This also covers n values that are not a power of two.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/switch_rr_arb.sv
// N-way round-robin arbiter.
// The grant is combinational and one-hot. It goes to the first request found
// by scanning from the priority pointer. The pointer then moves to the slot
// after the winner.
module switch_rr_arb
    import switch_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    output logic [N-1:0] o_grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next_ptr;
    logic [N-1:0]  w_grant;
    logic          w_found;

    // Scan requests starting at the priority pointer and pick the first active one.
    always_comb begin : p_grant
        int idx;
        // NOTE: every variable gets a default before any branch; a path that leaves one unassigned infers a latch.
        idx        = 0;
        w_grant    = '0;
        w_found    = 1'b0;
        w_next_ptr = r_ptr;
        if (i_en) begin
            for (int k = 0; k < N; k++) begin
                idx = (int'(r_ptr) + k) % N;
                if (!w_found && i_req[idx]) begin
                    w_grant[idx] = 1'b1;
                    w_found      = 1'b1;
                    w_next_ptr   = PW'(wrap_inc(idx, N));
                end
            end
        end
    end

    // Move priority past the winner; hold the pointer when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_next_ptr;
        end
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/switch_egress_arbiter.sv
// Per-output egress scheduler.
// Each cycle it grants one requester that targets PORT_ID, using round-robin
// order. The granted packet is queued in a local FIFO. Backpressure through
// req_ready means colliding requests wait rather than being dropped.
module switch_egress_arbiter
    import switch_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int PORT_ID    = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [N_REQ-1:0]                   req_valid,
    input  logic [N_REQ-1:0][ADDR_W-1:0]       req_source,
    input  logic [N_REQ-1:0][ADDR_W-1:0]       req_target,
    input  logic [N_REQ-1:0][DATA_W-1:0]       req_data,
    output logic [N_REQ-1:0]                   req_ready,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ADDR_W-1:0]                  out_source,
    output logic [ADDR_W-1:0]                  out_target,
    output logic [DATA_W-1:0]                  out_data,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_count,
    output logic                               fifo_full,
    output logic [15:0]                        pkt_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    pkt_t             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [15:0]      r_pkt_count;

    logic [N_REQ-1:0] w_active;
    logic [N_REQ-1:0] w_grant;
    logic             w_out_valid;
    logic             w_pop;
    logic             w_push_ok;
    logic             w_arb_en;
    logic             w_push;
    pkt_t             w_push_pkt;
    pkt_t             w_head;

    // A requester competes only when it holds a packet addressed to this output.
    always_comb begin
        w_active = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_active[i] = req_valid[i] & req_target[i][PORT_ID];
        end
    end

    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid & out_ready;
    // A full FIFO can still accept a packet when a pop frees a slot in the same cycle.
    assign w_push_ok   = (r_count < DEPTH_C) | w_pop;
    // Gating with rst_n keeps req_ready low while reset is held, without waiting for a clock edge.
    assign w_arb_en    = w_push_ok & rst_n;

    switch_rr_arb #(
        .N (N_REQ)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (w_active),
        .i_en    (w_arb_en),
        .o_grant (w_grant)
    );

    assign w_push = |w_grant;

    // Select the granted requester's fields. The grant is one-hot, so OR-ing the fields is safe.
    always_comb begin
        w_push_pkt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_push_pkt = '{source: req_source[i], target: req_target[i], data: req_data[i]};
            end
        end
    end

    // Write the granted packet into FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; the pointers and the count alone decide which entries are valid.
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_pkt;
        end
    end

    // Pointers, occupancy and the accepted-packet counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pkt_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + PTR_W'(1);
                r_pkt_count <= r_pkt_count + 16'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    // The head is read straight from storage. Fields are forced to zero while the FIFO is empty.
    always_comb begin
        out_valid  = w_out_valid;
        out_source = '0;
        out_target = '0;
        out_data   = '0;
        if (w_out_valid) begin
            out_source = w_head.source;
            out_target = w_head.target;
            out_data   = w_head.data;
        end
    end

    assign req_ready  = w_grant;
    assign fifo_count = r_count;
    assign fifo_full  = (r_count == DEPTH_C);
    assign pkt_count  = r_pkt_count;

endmodule

// File: tb/tb_switch_egress_arbiter.sv
// Directed bench for switch_egress_arbiter with PORT_ID=0, N_REQ=4 and FIFO_DEPTH=8.
`timescale 1ns/1ps
module tb_switch_egress_arbiter;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req_valid;
    logic [3:0][3:0]  req_source;
    logic [3:0][3:0]  req_target;
    logic [3:0][7:0]  req_data;
    logic [3:0]       req_ready;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_source;
    logic [3:0]       out_target;
    logic [7:0]       out_data;
    logic [3:0]       fifo_count;
    logic             fifo_full;
    logic [15:0]      pkt_count;

    int checks = 0;
    int errors = 0;

    switch_egress_arbiter #(
        .N_REQ      (4),
        .PORT_ID    (0),
        .FIFO_DEPTH (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_source (req_source),
        .req_target (req_target),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_source (out_source),
        .out_target (out_target),
        .out_data   (out_data),
        .fifo_count (fifo_count),
        .fifo_full  (fifo_full),
        .pkt_count  (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after a rising edge. Registered outputs are read at that same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid  = '0;
        req_source = '0;
        req_target = '0;
        req_data   = '0;
        out_ready  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            req_target[i] = 4'b0001;
            req_data[i]   = 8'hFF;
        end
        out_ready = 1'b1;
        tick();
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if ({out_source, out_target, out_data} !== 16'h0) begin errors++; $display("FAIL reset_out_fields got %h exp 0000", {out_source, out_target, out_data}); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_fifo_count got %0d exp 0", fifo_count); end
        checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL reset_pkt_count got %0d exp 0", pkt_count); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_fifo_full got %b exp 0", fifo_full); end
        clear_inputs();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_single();
        req_valid     = 4'b0010;
        req_source[1] = 4'd1;
        req_target[1] = 4'b0001;
        req_data[1]   = 8'hA5;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_req_ready got %b exp 0010", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b exp 1", out_valid); end
        checks++; if (out_source !== 4'd1) begin errors++; $display("FAIL single_out_source got %0d exp 1", out_source); end
        checks++; if (out_target !== 4'b0001) begin errors++; $display("FAIL single_out_target got %b exp 0001", out_target); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_out_data got %h exp a5", out_data); end
        checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL single_pkt_count got %0d exp 1", pkt_count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        checks++; if (fifo_count !== 4'd0 || out_data !== 8'h00) begin errors++; $display("FAIL single_pop got count %0d data %h exp 0 00", fifo_count, out_data); end
    endtask

    task automatic test_round_robin();
        int seq [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_source[i] = 4'(i);
            req_target[i] = 4'b0001;
            req_data[i]   = 8'h10 + 8'(i);
        end
        req_valid = 4'hF;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (req_ready !== 4'(1 << seq[c])) begin errors++; $display("FAIL rr_grant cycle %0d got %b exp %b", c, req_ready, 4'(1 << seq[c])); end
            tick();
            checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL rr_count cycle %0d got %0d exp 1", c, fifo_count); end
            checks++; if (out_data !== 8'h10 + 8'(seq[c])) begin errors++; $display("FAIL rr_head cycle %0d got %h exp %h", c, out_data, 8'h10 + 8'(seq[c])); end
        end
        req_valid = '0;
        tick();
        out_ready = 1'b0;
        #1;
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rr_drain got %0d exp 0", fifo_count); end
    endtask

    task automatic test_full();
        do_reset();
        req_valid     = 4'b0001;
        req_source[0] = 4'd0;
        req_target[0] = 4'b0001;
        for (int d = 0; d < 9; d++) begin
            req_data[0] = 8'(d);
            #1;
            if (d < 8) begin
                checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL full_fill_ready d=%0d got %b exp 0001", d, req_ready); end
                tick();
            end else begin
                checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL full_blocked_ready got %b exp 0000", req_ready); end
            end
        end
        checks++; if (fifo_full !== 1'b1 || fifo_count !== 4'd8) begin errors++; $display("FAIL full_state got full %b count %0d exp 1 8", fifo_full, fifo_count); end
        checks++; if (pkt_count !== 16'd8) begin errors++; $display("FAIL full_pkt_count got %0d exp 8", pkt_count); end
        checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL full_head got %h exp 00", out_data); end
        out_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL full_pop_push_ready got %b exp 0001", req_ready); end
        tick();
        out_ready = 1'b0;
        req_valid = '0;
        #1;
        checks++; if (fifo_count !== 4'd8 || fifo_full !== 1'b1) begin errors++; $display("FAIL full_swap_count got %0d full %b exp 8 1", fifo_count, fifo_full); end
        checks++; if (pkt_count !== 16'd9) begin errors++; $display("FAIL full_swap_pkt got %0d exp 9", pkt_count); end
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'(k)) begin errors++; $display("FAIL full_drain k=%0d got valid %b data %h exp 1 %h", k, out_valid, out_data, 8'(k)); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (fifo_count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL full_empty got count %0d valid %b exp 0 0", fifo_count, out_valid); end
    endtask

    task automatic test_masked();
        int seen = 0;
        do_reset();
        req_valid     = 4'b0100;
        req_source[2] = 4'd2;
        req_target[2] = 4'b1110;
        req_data[2]   = 8'h5A;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (req_ready[2] === 1'b1) seen++;
            tick();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL masked_ready got %0d grants exp 0", seen); end
        checks++; if (pkt_count !== 16'd0 || fifo_count !== 4'd0) begin errors++; $display("FAIL masked_counts got pkt %0d fifo %0d exp 0 0", pkt_count, fifo_count); end
        req_valid = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req_valid     = 4'b1000;
        req_source[3] = 4'd3;
        req_target[3] = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            req_data[3] = 8'h30 + 8'(k);
            tick();
        end
        req_valid = '0;
        #1;
        checks++; if (fifo_count !== 4'd5) begin errors++; $display("FAIL areset_pre_count got %0d exp 5", fifo_count); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin errors++; $display("FAIL areset_immediate got valid %b count %0d exp 0 0", out_valid, fifo_count); end
        checks++; if (out_data !== 8'h00 || pkt_count !== 16'd0) begin errors++; $display("FAIL areset_outputs got data %h pkt %0d exp 00 0", out_data, pkt_count); end
        tick();
        rst_n = 1'b1;
        req_valid     = 4'b0010;
        req_source[1] = 4'd1;
        req_target[1] = 4'b0001;
        req_data[1]   = 8'h77;
        tick();
        req_valid = '0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h77) begin errors++; $display("FAIL areset_first_push got valid %b data %h exp 1 77", out_valid, out_data); end
        checks++; if (fifo_count !== 4'd1 || pkt_count !== 16'd1) begin errors++; $display("FAIL areset_counts got fifo %0d pkt %0d exp 1 1", fifo_count, pkt_count); end
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_masked();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
